// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock timekeeping controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [3:0] SEC_MAX_H = 4'd5;
  localparam logic [3:0] SEC_MAX_L = 4'd9;
  localparam logic [3:0] MIN_MAX_H = 4'd5;
  localparam logic [3:0] MIN_MAX_L = 4'd9;

  localparam int BLINK_HOUR = 2;
  localparam int BLINK_MIN  = 1;
  localparam int BLINK_SEC  = 0;

  // Exact-match compare; out-of-range BCD never produces a carry.
  function automatic logic bcd_is(input logic [3:0] hi, input logic [3:0] lo,
                                  input logic [3:0] max_hi, input logic [3:0] max_lo);
    return (hi == max_hi) && (lo == max_lo);
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV clocks,
// plus a half-period phase used for display blinking.
module clk_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] r_pcnt;

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pcnt <= '0;
    end else if (tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  assign tick  = (r_pcnt == PW'(TICK_DIV - 1));
  assign phase = (r_pcnt < PW'(TICK_DIV / 2));

endmodule

// File: rtl/clock_ctrl.sv
// Timekeeping and time-set controller: counter enables with BCD carry
// cascade, RUN/SET_HOUR/SET_MIN mode FSM with idle timeout, blink masks.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] secH,
  input  logic [3:0] secL,
  input  logic [3:0] minH,
  input  logic [3:0] minL,
  input  logic [3:0] hourH,
  input  logic [3:0] hourL,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       tick_1hz,
  output logic [1:0] mode,
  output logic [2:0] blink_mask
);

  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);

  state_t            r_state;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_en_sec;
  logic              r_en_min;
  logic              r_en_hour;
  logic              r_tick_1hz;
  logic [2:0]        r_blink_mask;

  state_t            w_state_next;
  logic [IDLE_W-1:0] w_idle_next;
  logic              w_en_sec_next;
  logic              w_en_min_next;
  logic              w_en_hour_next;
  logic [2:0]        w_blink_next;
  logic              w_clr;
  logic              w_tick;
  logic              w_phase;
  logic              w_sec_59;
  logic              w_min_59;
  logic              w_idle_last;
  logic              w_unused;

  clk_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .tick  (w_tick),
    .phase (w_phase)
  );

  assign w_sec_59    = bcd_is(secH, secL, SEC_MAX_H, SEC_MAX_L);
  assign w_min_59    = bcd_is(minH, minL, MIN_MAX_H, MIN_MAX_L);
  assign w_idle_last = ((r_idle_cnt + IDLE_W'(1)) == IDLE_W'(TIMEOUT_S));
  // Hours never carry anywhere; the digits are part of the counter bundle only.
  assign w_unused    = ^{hourH, hourL};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    w_state_next   = r_state;
    w_idle_next    = r_idle_cnt;
    w_en_sec_next  = 1'b0;
    w_en_min_next  = 1'b0;
    w_en_hour_next = 1'b0;
    w_blink_next   = 3'b111;

    case (r_state)
      RUN: begin
        if (w_tick) begin
          w_en_sec_next  = 1'b1;
          w_en_min_next  = w_sec_59;
          w_en_hour_next = w_sec_59 && w_min_59;
        end
        if (btn_mode) begin
          w_state_next = SET_HOUR;
          w_idle_next  = '0;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (btn_mode) begin
          w_state_next = (r_state == SET_HOUR) ? SET_MIN : RUN;
          w_idle_next  = '0;
        end else if (btn_inc) begin
          w_en_hour_next = (r_state == SET_HOUR);
          w_en_min_next  = (r_state == SET_MIN);
          w_idle_next    = '0;
        end else if (w_tick) begin
          if (w_idle_last) begin
            w_state_next = RUN;
            w_idle_next  = '0;
          end else begin
            w_idle_next = r_idle_cnt + IDLE_W'(1);
          end
        end
      end
      default: w_state_next = RUN;
    endcase

    // Every return to RUN restarts the second so the next tick is a full period away.
    w_clr = (w_state_next == RUN) && (r_state != RUN);

    if (w_state_next == SET_HOUR) w_blink_next[BLINK_HOUR] = w_phase;
    if (w_state_next == SET_MIN)  w_blink_next[BLINK_MIN]  = w_phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_idle_cnt   <= '0;
      r_en_sec     <= 1'b0;
      r_en_min     <= 1'b0;
      r_en_hour    <= 1'b0;
      r_tick_1hz   <= 1'b0;
      r_blink_mask <= 3'b111;
    end else begin
      r_state      <= w_state_next;
      r_idle_cnt   <= w_idle_next;
      r_en_sec     <= w_en_sec_next;
      r_en_min     <= w_en_min_next;
      r_en_hour    <= w_en_hour_next;
      r_tick_1hz   <= w_tick;
      r_blink_mask <= w_blink_next;
    end
  end

  assign en_sec     = r_en_sec;
  assign en_min     = r_en_min;
  assign en_hour    = r_en_hour;
  assign tick_1hz   = r_tick_1hz;
  assign mode       = r_state;
  assign blink_mask = r_blink_mask;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus randomized
// buttons/time values, checked against a time-and-mode reference model.
module tb_clock_ctrl;

  localparam int TD = 10;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] secH = '0, secL = '0, minH = '0, minL = '0, hourH = '0, hourL = '0;
  logic       en_sec, en_min, en_hour, tick_1hz;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic [8:0] obs;
  logic [8:0] exp_vec;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode number, position within the current second, idle seconds.
  int m_mode = 0;
  int m_pcnt = 0;
  int m_idle = 0;

  always #5 clk = ~clk;

  clock_ctrl #(
    .TICK_DIV  (TD),
    .TIMEOUT_S (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .secH       (secH),
    .secL       (secL),
    .minH       (minH),
    .minL       (minL),
    .hourH      (hourH),
    .hourL      (hourL),
    .en_sec     (en_sec),
    .en_min     (en_min),
    .en_hour    (en_hour),
    .tick_1hz   (tick_1hz),
    .mode       (mode),
    .blink_mask (blink_mask)
  );

  assign obs = {en_sec, en_min, en_hour, tick_1hz, mode, blink_mask};

  function automatic int bcd_val(input logic [3:0] h, input logic [3:0] l);
    if (h > 4'd9 || l > 4'd9) return -1;
    return int'(h) * 10 + int'(l);
  endfunction

  // Predicts the outputs visible after the coming clock edge from the current inputs.
  task automatic model_step();
    bit tick, phase, es, em, eh;
    int nm, np;
    logic [2:0] bl;
    if (rst) begin
      m_mode = 0; m_pcnt = 0; m_idle = 0;
      exp_vec = {4'b0000, 2'd0, 3'b111};
      return;
    end
    tick = (m_pcnt == TD - 1);
    phase = (m_pcnt < TD / 2);
    es = 0; em = 0; eh = 0;
    nm = m_mode;
    np = (m_pcnt + 1) % TD;
    if (m_mode == 0) begin
      if (tick) begin
        es = 1;
        em = (bcd_val(secH, secL) == 59);
        eh = em && (bcd_val(minH, minL) == 59);
      end
      if (btn_mode) begin nm = 1; m_idle = 0; end
    end else if (btn_mode) begin
      nm = (m_mode + 1) % 3; m_idle = 0;
    end else if (btn_inc) begin
      eh = (m_mode == 1); em = (m_mode == 2); m_idle = 0;
    end else if (tick) begin
      m_idle++;
      if (m_idle == TO) begin nm = 0; m_idle = 0; end
    end
    if (nm == 0 && m_mode != 0) np = 0;
    bl = 3'b111;
    if (nm == 1) bl[2] = phase;
    if (nm == 2) bl[1] = phase;
    exp_vec = {es, em, eh, tick, 2'(nm), bl};
    m_mode = nm;
    m_pcnt = np;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [23:0] t);
    {hourH, hourL, minH, minL, secH, secL} = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_time(24'h000000);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs !== {4'b0000, 2'd0, 3'b111}) begin
        miscompares++;
        $display("FAIL reset_state got=%b want=%b", obs, {4'b0000, 2'd0, 3'b111});
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      step();
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_run_model c=%0d got=%b want=%b", c, obs, exp_vec);
      end
      vectors++;
      if ({en_sec, tick_1hz, en_min, en_hour} !== {(c % 10 == 0), (c % 10 == 0), 2'b00}) begin
        miscompares++;
        $display("FAIL reset_first_ticks c=%0d got sec/tick/min/hour=%b%b%b%b", c,
                 en_sec, tick_1hz, en_min, en_hour);
      end
    end
  endtask

  task automatic test_carry();
    logic [23:0] times [2];
    logic [2:0]  want [2];
    bit found;
    times = '{24'h235959, 24'h123459};
    want  = '{3'b111, 3'b110};
    for (int k = 0; k < 2; k++) begin
      set_time(times[k]);
      found = 0;
      for (int c = 0; c < 12 && !found; c++) begin
        step();
        vectors++;
        if (obs !== exp_vec) begin
          miscompares++;
          $display("FAIL carry_model k=%0d got=%b want=%b", k, obs, exp_vec);
        end
        if (en_sec === 1'b1) begin
          found = 1;
          vectors++;
          if ({en_sec, en_min, en_hour} !== want[k]) begin
            miscompares++;
            $display("FAIL carry_enables k=%0d got=%b want=%b", k, {en_sec, en_min, en_hour}, want[k]);
          end
        end
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL carry_no_tick k=%0d got=no en_sec want=en_sec within 12 cycles", k);
      end
      step();
      vectors++;
      if ({en_sec, en_min, en_hour} !== 3'b000) begin
        miscompares++;
        $display("FAIL carry_single_cycle k=%0d got=%b want=000", k, {en_sec, en_min, en_hour});
      end
    end
  endtask

  task automatic test_set_hour();
    set_time(24'h081530);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    vectors++;
    if (mode !== 2'd1 || obs !== exp_vec) begin
      miscompares++;
      $display("FAIL set_hour_entry got=%b want=%b", obs, exp_vec);
    end
    for (int i = 0; i < 25; i++) begin
      btn_inc = (i == 3 || i == 14);
      step();
      btn_inc = 1'b0;
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL set_hour_model i=%0d got=%b want=%b", i, obs, exp_vec);
      end
      vectors++;
      if ({en_sec, en_min, en_hour, mode} !== {2'b00, (i == 3 || i == 14), 2'd1}) begin
        miscompares++;
        $display("FAIL set_hour_enables i=%0d got sec/min/hour/mode=%b%b%b/%0d", i,
                 en_sec, en_min, en_hour, mode);
      end
    end
  endtask

  task automatic test_set_min();
    set_time(24'h125959);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    vectors++;
    if (mode !== 2'd2 || obs !== exp_vec) begin
      miscompares++;
      $display("FAIL set_min_entry got=%b want=%b", obs, exp_vec);
    end
    btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
    vectors++;
    if ({en_sec, en_min, en_hour} !== 3'b010 || obs !== exp_vec) begin
      miscompares++;
      $display("FAIL set_min_inc_59 got=%b want=%b", obs, exp_vec);
    end
    step();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    vectors++;
    if (mode !== 2'd0 || en_min !== 1'b0 || obs !== exp_vec) begin
      miscompares++;
      $display("FAIL set_min_mode_wins got=%b want=%b", obs, exp_vec);
    end
  endtask

  task automatic test_timeout();
    int back, first_sec;
    set_time(24'h010203);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    back = -1;
    for (int c = 1; c <= 40 && back < 0; c++) begin
      step();
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL timeout_model c=%0d got=%b want=%b", c, obs, exp_vec);
      end
      if (mode === 2'd0) back = c;
    end
    vectors++;
    if (back < 21 || back > 31) begin
      miscompares++;
      $display("FAIL timeout_exit got=%0d cycles want=21..31", back);
    end
    first_sec = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL timeout_run_model c=%0d got=%b want=%b", c, obs, exp_vec);
      end
      if (en_sec === 1'b1 && first_sec < 0) first_sec = c;
    end
    vectors++;
    if (first_sec !== 10) begin
      miscompares++;
      $display("FAIL timeout_first_sec got=%0d want=10", first_sec);
    end
  endtask

  task automatic test_reset_in_set();
    int first_sec;
    set_time(24'h224411);
    for (int i = 0; i < 2; i++) begin
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
    end
    vectors++;
    if (mode !== 2'd2) begin
      miscompares++;
      $display("FAIL rst_set_entry got=%0d want=2", mode);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (obs !== {4'b0000, 2'd0, 3'b111}) begin
      miscompares++;
      $display("FAIL rst_set_state got=%b want=%b", obs, {4'b0000, 2'd0, 3'b111});
    end
    first_sec = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL rst_set_model c=%0d got=%b want=%b", c, obs, exp_vec);
      end
      if (en_sec === 1'b1 && first_sec < 0) first_sec = c;
    end
    vectors++;
    if (first_sec !== 10) begin
      miscompares++;
      $display("FAIL rst_set_first_sec got=%0d want=10", first_sec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      btn_mode = ($urandom_range(0, 19) == 0);
      btn_inc  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) begin
        secH = 4'd5; secL = 4'd9;
      end else begin
        secH = 4'($urandom_range(0, 15)); secL = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1) begin
        minH = 4'd5; minL = 4'd9;
      end else begin
        minH = 4'($urandom_range(0, 15)); minL = 4'($urandom_range(0, 15));
      end
      hourH = 4'($urandom_range(0, 2));
      hourL = 4'($urandom_range(0, 9));
      step();
      rst = 1'b0;
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL random_model i=%0d got=%b want=%b", i, obs, exp_vec);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_carry();
    test_set_hour();
    test_set_min();
    test_timeout();
    test_reset_in_set();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got=time limit reached want=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
